// File: rtl/axi_burst_master.sv
// AXI3-style burst initiator: one command at a time from a simple cmd/data stream
// onto AW/W/B or AR/R, with illegal commands rejected before any bus traffic.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// CHECK  | one cycle legality check of the latched command
// WADDR  | AW presented until accepted
// WDATA  | write beats passed through from wd_* to w_*
// WRESP  | waiting for B
// RADDR  | AR presented until accepted
// RDATA  | read beats passed through from r_* to rd_*
// DONE   | one cycle done pulse carrying the final response
module axi_burst_master #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  a_clk,
  input  logic                  a_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [3:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_W-1:0]     wd_data,
  input  logic [DATA_W/8-1:0]   wd_strb,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  done_valid,
  output logic [1:0]            done_resp,
  output logic [ID_W-1:0]       aw_id,
  output logic [ADDR_W-1:0]     aw_addr,
  output logic [3:0]            aw_len,
  output logic [2:0]            aw_size,
  output logic [1:0]            aw_burst,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_W-1:0]     w_data,
  output logic [DATA_W/8-1:0]   w_strb,
  output logic                  w_last,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic [ID_W-1:0]       b_id,
  input  logic [1:0]            b_resp,
  input  logic                  b_valid,
  output logic                  b_ready,
  output logic [ID_W-1:0]       ar_id,
  output logic [ADDR_W-1:0]     ar_addr,
  output logic [3:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [ID_W-1:0]       r_id,
  input  logic [DATA_W-1:0]     r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  input  logic                  r_valid,
  output logic                  r_ready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int MAXSZ  = $clog2(STRB_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t              state, state_n;
  logic                write_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [3:0]          beat_cnt, beat_n;
  logic [1:0]          resp_q, resp_n;

  logic                run;
  logic                illegal;
  logic                wrap_len_ok;
  logic [ADDR_W-1:0]   align_mask;
  logic [12:0]         burst_bytes;
  logic [12:0]         page_end;

  assign run = !a_reset;

  // A burst spans at most 2 KiB, so the 4 KiB crossing of the full-width end
  // address reduces to the page offset plus length overflowing one page.
  assign burst_bytes = 13'({1'b0, len_q} + 5'd1) << size_q;
  assign page_end    = {1'b0, addr_q[11:0]} + burst_bytes;
  assign align_mask  = ~({ADDR_W{1'b1}} << size_q);
  assign wrap_len_ok = (len_q == 4'd1) || (len_q == 4'd3) || (len_q == 4'd7) || (len_q == 4'd15);

  always_comb begin
    illegal = 1'b0;
    if (burst_q == 2'b11)                             illegal = 1'b1;
    if (size_q > 3'(MAXSZ))                           illegal = 1'b1;
    if (burst_q == 2'b10 && !wrap_len_ok)             illegal = 1'b1;
    if (burst_q == 2'b10 && |(addr_q & align_mask))   illegal = 1'b1;
    if (burst_q == 2'b01 && page_end > 13'h1000)      illegal = 1'b1;
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      state    <= S_IDLE;
      write_q  <= 1'b0;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      resp_q   <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_n;
      resp_q   <= resp_n;
      if (state == S_IDLE && cmd_valid) begin
        write_q <= cmd_write;
        id_q    <= cmd_id;
        addr_q  <= cmd_addr;
        len_q   <= cmd_len;
        size_q  <= cmd_size;
        burst_q <= cmd_burst;
      end
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    resp_n  = resp_q;
    case (state)
      S_IDLE:  if (cmd_valid) state_n = S_CHECK;
      S_CHECK: begin
        if (illegal) begin
          resp_n  = 2'b10;
          state_n = S_DONE;
        end else begin
          state_n = write_q ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        if (aw_ready) begin
          beat_n  = '0;
          state_n = S_WDATA;
        end
      end
      S_WDATA: begin
        if (wd_valid && w_ready) begin
          if (beat_cnt == len_q) state_n = S_WRESP;
          else                   beat_n  = beat_cnt + 4'd1;
        end
      end
      S_WRESP: begin
        if (b_valid) begin
          resp_n  = (b_id != id_q) ? 2'b10 : b_resp;
          state_n = S_DONE;
        end
      end
      S_RADDR: begin
        if (ar_ready) begin
          beat_n  = '0;
          resp_n  = '0;
          state_n = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_valid && rd_ready) begin
          resp_n = (r_resp > resp_q) ? r_resp : resp_q;
          if (r_id != id_q) resp_n = 2'b10;
          if (r_last || beat_cnt == len_q) begin
            // early r_last, or a final beat without r_last, both abort the burst
            if (r_last != (beat_cnt == len_q)) resp_n = 2'b10;
            state_n = S_DONE;
          end else begin
            beat_n = beat_cnt + 4'd1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign cmd_ready  = run && (state == S_IDLE);

  assign aw_valid   = run && (state == S_WADDR);
  assign aw_id      = id_q;
  assign aw_addr    = addr_q;
  assign aw_len     = len_q;
  assign aw_size    = size_q;
  assign aw_burst   = burst_q;

  assign w_valid    = run && (state == S_WDATA) && wd_valid;
  assign wd_ready   = run && (state == S_WDATA) && w_ready;
  assign w_data     = wd_data;
  assign w_strb     = wd_strb;
  assign w_last     = (beat_cnt == len_q);

  assign b_ready    = run && (state == S_WRESP);

  assign ar_valid   = run && (state == S_RADDR);
  assign ar_id      = id_q;
  assign ar_addr    = addr_q;
  assign ar_len     = len_q;
  assign ar_size    = size_q;
  assign ar_burst   = burst_q;

  assign rd_valid   = run && (state == S_RDATA) && r_valid;
  assign r_ready    = run && (state == S_RDATA) && rd_ready;
  assign rd_data    = r_data;
  assign rd_resp    = r_resp;
  assign rd_last    = r_last;

  assign done_valid = run && (state == S_DONE);
  assign done_resp  = resp_q;

endmodule
